// File: rtl/piso_tx_pkg.sv
// Shared types and helpers for the PISO transmit scheduler.
// Holds the FSM state encoding, default sizes and the round-robin pick function.
// Optional parity framing is selected with the PISO_TX_PARITY_EN macro.
package piso_tx_pkg;

    localparam int PISO_DATA_W = 16;
    localparam int PISO_NUM_REQ = 4;

    // Widest requester vector the round-robin helper supports.
    localparam int RR_MAX = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    // First set bit of valid[n-1:0] searching upward from ptr+1 with wrap-around.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic logic [2:0] rr_next(input logic [RR_MAX-1:0] valid,
                                           input logic [2:0]        ptr,
                                           input int                n);
        logic [2:0] win;
        logic [2:0] idx;
        logic       found;
        win   = 3'd0;
        found = 1'b0;
        for (int i = 1; i <= RR_MAX; i++) begin
            if (i <= n) begin
                idx = 3'((int'(ptr) + i) % n);
                if (!found && valid[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/piso_tx_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and encoded index from valid and last-winner pointer.
// Purely combinational, zero latency.
// No grant unless advance is high; the caller owns and updates the pointer.
module rr_arbiter
    import piso_tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    pointer,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    index
);

    logic [RR_MAX-1:0] valid_ext;
    logic [2:0]        ptr_ext;
    logic [2:0]        win;

    // Pick the next winner after the pointer and raise its grant when allowed.
    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = valid;
        ptr_ext                  = 3'(pointer);
        win                      = rr_next(valid_ext, ptr_ext, NUM_REQ);
        index                    = ID_W'(win);
        grant                    = '0;
        if (advance && (|valid)) begin
            grant[index] = 1'b1;
        end
    end

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin scheduler feeding one LSB-first PISO shifter with framing strobes.
// Grant/load is combinational in the grant cycle; bit 0 leaves the shifter one cycle later.
// A word is consumed only on valid&ready; enable low blocks new grants, in-flight word completes.
// Optional macro PISO_TX_PARITY_EN appends a one-cycle even-parity slot after each word.
module piso_tx_sched
    import piso_tx_pkg::*;
#(
    parameter int NUM_REQ = PISO_NUM_REQ,
    parameter int DATA_W  = PISO_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         piso_din,
    output logic                      piso_din_en,
    output logic                      ser_valid,
    output logic                      ser_first,
    output logic                      ser_last,
    output logic [ID_W-1:0]           ser_id,
`ifdef PISO_TX_PARITY_EN
    output logic                      ser_par,
    output logic                      ser_par_valid,
`endif
    output logic                      busy
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
`ifdef PISO_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic               grant_opp;
    logic               advance;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;

    // States in which a new word may be accepted.
    always_comb begin
`ifdef PISO_TX_PARITY_EN
        grant_opp = (state_q == IDLE) || (state_q == PARITY);
`else
        grant_opp = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == CNT_LAST));
`endif
        advance = grant_opp && enable && !rst;
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .valid   (req_valid),
        .pointer (ptr_q),
        .advance (advance),
        .grant   (gnt),
        .index   (gnt_idx)
    );

    assign gnt_any = |gnt;

    // Route the winner's word to the shifter in the grant cycle only.
    always_comb begin
        req_ready   = gnt;
        piso_din_en = gnt_any;
        piso_din    = '0;
        if (gnt_any) begin
            piso_din = req_data[gnt_idx*DATA_W +: DATA_W];
        end
    end

    // Framing strobes follow the registered state so they line up with shifter dout.
    always_comb begin
        ser_valid = (state_q == SHIFT);
        ser_first = (state_q == SHIFT) && (cnt_q == '0);
        ser_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        ser_id    = id_q;
        busy      = (state_q != IDLE);
`ifdef PISO_TX_PARITY_EN
        ser_par_valid = (state_q == PARITY);
        ser_par       = (state_q == PARITY) && par_q;
`endif
    end

    // Next-state: count bits through SHIFT; a grant restarts the word from bit 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
`ifdef PISO_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (gnt_any) begin
            state_d = SHIFT;
            cnt_d   = '0;
            ptr_d   = gnt_idx;
            id_d    = gnt_idx;
`ifdef PISO_TX_PARITY_EN
            par_d   = ^piso_din;
`endif
        end
    end

    // State registers; pointer resets to the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
`ifdef PISO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
`ifdef PISO_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_tx_sched.sv
// Scoreboard bench for piso_tx_sched: stimulus queues expected grants and frames,
// a negedge monitor compares loads and serial framing as the DUT presents them.
// Build with PISO_TX_PARITY_EN defined to exercise the parity slot.
module tb_piso_tx_sched;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [NR-1:0]    req_valid;
    logic [DW-1:0]    rd [NR];
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    piso_din;
    logic             piso_din_en;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic [IW-1:0]    ser_id;
    logic             busy;
`ifdef PISO_TX_PARITY_EN
    logic             ser_par;
    logic             ser_par_valid;
`endif

    always #5 clk = ~clk;

    assign req_data = {rd[3], rd[2], rd[1], rd[0]};

    piso_tx_sched #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .piso_din      (piso_din),
        .piso_din_en   (piso_din_en),
        .ser_valid     (ser_valid),
        .ser_first     (ser_first),
        .ser_last      (ser_last),
        .ser_id        (ser_id),
`ifdef PISO_TX_PARITY_EN
        .ser_par       (ser_par),
        .ser_par_valid (ser_par_valid),
`endif
        .busy          (busy)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_g[$];
    exp_t exp_f[$];
    exp_t e;
    exp_t cur;

    int checks   = 0;
    int errors   = 0;
    int gnt_cnt  = 0;
    int pos      = 0;
    int run      = 0;
    int last_run = 0;
    int cyc      = 0;
    int last_gnt_cyc = 0;
    int gnt_gap  = 0;
    int par_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id);
        exp_t x;
        x.id   = IW'(id);
        x.data = rd[id];
        exp_g.push_back(x);
        exp_f.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int target;
        int k;
        target = gnt_cnt + n;
        k = 0;
        while (gnt_cnt < target && k < 400) begin
            sample();
            k++;
        end
        chk("grant_wait", 32'(gnt_cnt >= target), 32'(1));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        sample();
        while (busy && k < 200) begin
            sample();
            k++;
        end
        chk("idle_wait", 32'(busy), 32'(0));
    endtask

    task automatic do_reset();
        chk("queues_drained", 32'(exp_g.size() + exp_f.size()), 32'(0));
        rst       = 1'b1;
        enable    = 1'b1;
        req_valid = '0;
        step();
        step();
        sample();
        chk("rst_ready",  32'(req_ready),   32'(0));
        chk("rst_din_en", 32'(piso_din_en), 32'(0));
        chk("rst_valid",  32'(ser_valid),   32'(0));
        chk("rst_busy",   32'(busy),        32'(0));
        chk("rst_id",     32'(ser_id),      32'(0));
        step();
        rst = 1'b0;
    endtask

    // Monitor: pops expected grants on each load and expected frames on each bit 0.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pos = 0;
            run = 0;
        end else begin
            if (piso_din_en) begin
                gnt_cnt++;
                gnt_gap = cyc - last_gnt_cyc;
                last_gnt_cyc = cyc;
                if (exp_g.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got ready %0h din %0h expected no grant",
                             req_ready, piso_din);
                end else begin
                    e = exp_g.pop_front();
                    chk("grant_ready", 32'(req_ready), 32'(1) << e.id);
                    chk("grant_din",   32'(piso_din),  32'(e.data));
                end
                if (busy) begin
`ifdef PISO_TX_PARITY_EN
                    chk("load_in_parity", 32'(ser_par_valid), 32'(1));
`else
                    chk("load_on_last", 32'(ser_last), 32'(1));
`endif
                end
            end else begin
                chk("ready_without_load", 32'(req_ready), 32'(0));
            end
            if (ser_valid) begin
                run++;
                if (pos == 0) begin
                    if (exp_f.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got id %0d expected no frame", ser_id);
                    end else begin
                        cur = exp_f.pop_front();
                    end
                end
                chk("ser_first", 32'(ser_first), 32'(pos == 0));
                chk("ser_last",  32'(ser_last),  32'(pos == DW - 1));
                chk("ser_id",    32'(ser_id),    32'(cur.id));
                pos = (pos + 1) % DW;
            end else begin
                if (run != 0) last_run = run;
                run = 0;
                if (pos != 0) begin
                    checks++;
                    errors++;
                    $display("FAIL truncated_word: got %0d bits expected %0d", pos, DW);
                end
                pos = 0;
`ifdef PISO_TX_PARITY_EN
                if (ser_par_valid) begin
                    par_seen++;
                    chk("ser_par", 32'(ser_par), 32'(^cur.data));
                end
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        req_valid = '0;
        rd        = '{16'hA5C3, 16'h1234, 16'hBEEF, 16'h0F0F};
        do_reset();

        // Single word from requester 0.
        push_exp(0);
        req_valid = 4'b0001;
        wait_grants(1);
        step();
        req_valid = '0;
        wait_idle();
        chk("single_run", 32'(last_run), 32'(16));

        // Round robin across all four, gapless.
        do_reset();
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        req_valid = 4'b1111;
        wait_grants(5);
        step();
        req_valid = '0;
        wait_idle();
`ifdef PISO_TX_PARITY_EN
        chk("rr_run", 32'(last_run), 32'(16));
`else
        chk("rr_run", 32'(last_run), 32'(80));
`endif

        // Fairness between 0 and 2, then 0 alone back to back.
        do_reset();
        push_exp(0); push_exp(2); push_exp(0); push_exp(2);
        req_valid = 4'b0101;
        wait_grants(4);
        step();
        req_valid = 4'b0001;
        push_exp(0); push_exp(0);
        wait_grants(2);
        step();
        req_valid = '0;
        wait_idle();
`ifndef PISO_TX_PARITY_EN
        chk("fair_run", 32'(last_run), 32'(96));
`endif

        // Enable dropped at cnt==5: word completes, no grants until re-enabled.
        do_reset();
        push_exp(0);
        req_valid = 4'b0011;
        wait_grants(1);
        step();
        repeat (5) step();
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample();
            chk("ready_gated", 32'(req_ready), 32'(0));
        end
        chk("gated_busy", 32'(busy), 32'(0));
        chk("gated_run",  32'(last_run), 32'(16));
        push_exp(1);
        step();
        enable = 1'b1;
        wait_grants(1);
        step();
        req_valid = '0;
        wait_idle();

        // Reset at cnt==7 of a word.
        do_reset();
        push_exp(0);
        req_valid = 4'b0001;
        wait_grants(1);
        step();
        req_valid = '0;
        repeat (7) step();
        rst = 1'b1;
        step();
        sample();
        chk("midrst_busy",  32'(busy),      32'(0));
        chk("midrst_valid", 32'(ser_valid), 32'(0));
        chk("midrst_ready", 32'(req_ready), 32'(0));
        step();
        rst = 1'b0;
        push_exp(0);
        req_valid = 4'b1111;
        wait_grants(1);
        step();
        req_valid = '0;
        wait_idle();

`ifdef PISO_TX_PARITY_EN
        // Parity slot after a word with three ones; 17-cycle period.
        do_reset();
        rd[0] = 16'h0007;
        par_seen = 0;
        push_exp(0); push_exp(0);
        req_valid = 4'b0001;
        wait_grants(2);
        step();
        req_valid = '0;
        wait_idle();
        sample();
        chk("parity_period", 32'(gnt_gap), 32'(17));
        chk("parity_slots",  32'(par_seen), 32'(2));
`endif

        chk("final_drain", 32'(exp_g.size() + exp_f.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_tx_sched.md
Name: piso_tx_sched

Overview:
- Round-robin scheduler that shares one 16-bit parallel-in/serial-out shift register (LSB-first, load on din_en, else shift right with zero fill) between NUM_REQ word producers.
- Arbitrates requests, drives the shifter's load interface, and counts shift cycles.
- Emits framing strobes (valid/first/last/id) aligned with the shifter's serial output.
- Sits between producer FIFOs and the serial-out datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, word width; must equal the shifter width.
- ID_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  permits new grants; an in-flight word always completes.
- req_valid  in  NUM_REQ  per-requester word available.
- req_data  in  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; the word is consumed when valid and ready are both high.
- piso_din  out  DATA_W  word routed to the shifter din.
- piso_din_en  out  1  shifter load strobe.
- ser_valid  out  1  shifter dout carries a payload bit this cycle.
- ser_first  out  1  bit 0 of the word.
- ser_last  out  1  bit DATA_W-1 of the word.
- ser_id  out  ID_W  requester owning the current word.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, bit counter=0, last-grant pointer=NUM_REQ-1 (requester 0 wins first), ser_id=0. All outputs 0.
- States: IDLE, SHIFT, plus PARITY when the optional feature is compiled in.
- Grant opportunity: in IDLE, or in SHIFT when cnt==DATA_W-1 and the optional feature is compiled out.
  - Condition: enable=1 and any req_valid set.
  - Winner: first valid requester searching from pointer+1 upward, with wrap-around.
  - Same cycle, combinationally: req_ready[g]=1, piso_din=req_data[g], piso_din_en=1.
  - Registered: pointer<=g, ser_id<=g, cnt<=0, state<=SHIFT.
  - req_ready depends on req_valid; req_valid must not depend on req_ready.
- Outside a grant: piso_din=0, piso_din_en=0.
- Latency: bit 0 appears on the shifter dout in the cycle after the load strobe.
- SHIFT:
  - Outputs: ser_valid=1, ser_first=(cnt==0), ser_last=(cnt==DATA_W-1); cnt increments each cycle.
  - At cnt==DATA_W-1: if a grant occurs, stay in SHIFT with cnt<=0 (gapless back-to-back); otherwise go to IDLE.
- enable low during SHIFT: the current word finishes, then IDLE; no grant is issued.
- Requester dropping req_valid before being granted: never granted; no side effects.
- Single active requester: granted repeatedly and gapless; the pointer does not starve it.
- Reset asserted mid-word: immediate return to IDLE. The word is lost, and the shifter is reset by the same rst.
- A cycle with ser_valid=0 means dout carries no payload.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - At each grant, even parity of the granted word is registered.
  - After the cnt==DATA_W-1 cycle the FSM enters PARITY for one cycle, with ser_valid=0.
  - Extra outputs in that cycle: ser_par=stored parity and ser_par_valid=1.
  - Grants are issued only from IDLE or PARITY, so the word period is DATA_W+1 cycles. Arbitration in PARITY follows the same rules as IDLE.
- Undefined:
  - No PARITY state, no ser_par or ser_par_valid ports.
  - The word period is DATA_W cycles, gapless.

Decomposition:
- Package piso_tx_pkg holds:
  - the state enum typedef (IDLE, SHIFT, PARITY);
  - default constants PISO_DATA_W=16 and PISO_NUM_REQ=4;
  - a function computing the next round-robin winner from (valid, pointer).
- One sub-module: rr_arbiter, parameterised by NUM_REQ, with inputs valid, pointer and advance, and outputs one-hot grant and encoded index.
- Data muxing and the FSM stay in piso_tx_sched.

Test Plan:
- Single word: after reset, req_valid=4'b0001, req_data[0]=16'hA5C3 for one handshake.
  - piso_din_en is high one cycle with piso_din=16'hA5C3.
  - The next 16 cycles have ser_valid=1; ser_first is on the first, ser_last on the 16th, ser_id=0.
  - Then IDLE with busy=0.
- Round robin: all four valid continuously; grant order is 0,1,2,3,0.
  - Each load strobe coincides with the previous word's ser_last, with no idle cycle.
  - ser_valid stays high for 80 consecutive cycles.
- Fairness: req 2 and req 0 both held valid; grants alternate 0,2,0,2.
  - Dropping req 2 afterwards gives back-to-back grants to 0.
- Enable gating: enable deasserted at cnt==5 of a word.
  - The word completes to ser_last, then IDLE.
  - No req_ready while enable=0; re-enable grants the next requester after the pointer.
- Reset mid-word: rst=1 at cnt==7.
  - Next cycle: busy=0, ser_valid=0, req_ready=0.
  - Fresh request after release: requester 0 wins.
- PISO_TX_PARITY_EN: word 16'h0007 (three ones).
  - In the cycle after ser_last: ser_par=1, ser_par_valid=1, ser_valid=0.
  - The next load strobe occurs in the PARITY cycle, giving a 17-cycle period.
